pipe_ctrl: RTL and testbench

Pipeline controller for the five-stage CPU. It merges stall requests from ID and EX into the per-stage stall vector, sequences multi-cycle EX operations with an internal countdown, and converts a MEM-stage exception request into a one-cycle flush with a redirect PC. It sits beside the pipeline registers: PC, IF/ID, ID/EX, EX/MEM and MEM/WB all take `stall` and `flush` from this block.

---
 rtl/pipe_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Five-stage pipeline controller: stall merge, multi-cycle EX
//               sequencing and MEM-exception flush/redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             mc_start,
    input  logic [CNT_W-1:0] mc_cycles,
    input  logic             mc_cancel,
    input  logic             flush_req,
    input  logic [31:0]      flush_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             mc_busy,
    output logic             mc_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MULTI = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [5:0] STALL_ID = 6'b000111;
    localparam logic [5:0] STALL_EX = 6'b001111;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [31:0]      pc_lat;
    logic [31:0]      pc_nx;
    logic             ex_hold;
    logic             mc_long;

    // Lengths 0 and 1 behave as ordinary single-cycle EX ops.
    assign mc_long = mc_start && (mc_cycles >= CNT_TWO);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pc_nx    = pc_lat;
        ex_hold  = stallreq_ex;
        mc_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (flush_req) begin
                    state_nx = S_FLUSH;
                    pc_nx    = flush_pc;
                end else if (mc_long) begin
                    ex_hold  = 1'b1;
                    state_nx = S_MULTI;
                    cnt_nx   = mc_cycles - CNT_TWO;
                end
            end
            S_MULTI: begin
                if (flush_req) begin
                    state_nx = S_FLUSH;
                    pc_nx    = flush_pc;
                end else if (mc_cancel) begin
                    state_nx = S_IDLE;
                end else if (cnt == '0) begin
                    mc_done  = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    ex_hold  = 1'b1;
                    cnt_nx   = cnt - CNT_ONE;
                end
            end
            S_FLUSH: begin
                if (flush_req) begin
                    pc_nx = flush_pc;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (rst) begin
            mc_done = 1'b0;
        end

        if (rst || flush_req || (state == S_FLUSH)) begin
            stall = 6'b000000;
        end else if (ex_hold) begin
            stall = STALL_EX;
        end else if (stallreq_id) begin
            stall = STALL_ID;
        end else begin
            stall = 6'b000000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            pc_lat <= 32'h0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            pc_lat <= pc_nx;
        end
    end

    // Pure decodes of flops, so these stay glitch-free registered outputs.
    assign flush   = (state == S_FLUSH);
    assign new_pc  = flush ? pc_lat : 32'h0;
    assign mc_busy = (state == S_MULTI);

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl (vector table + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    typedef struct {
        logic        rst;
        logic        sid;
        logic        sex;
        logic        start;
        logic [5:0]  cyc;
        logic        cancel;
        logic        freq;
        logic [31:0] fpc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    localparam logic [5:0] SI = 6'b000111;
    localparam logic [5:0] SE = 6'b001111;
    localparam logic [5:0] S0 = 6'b000000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_id = 1'b0;
    logic        stallreq_ex = 1'b0;
    logic        mc_start = 1'b0;
    logic [5:0]  mc_cycles = 6'd0;
    logic        mc_cancel = 1'b0;
    logic        flush_req = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_busy;
    logic        mc_done;

    int passed = 0;
    int total  = 0;
    vec_t sb[$];
    vec_t tbl[$];

    pipe_ctrl #(.CNT_W(6)) dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
        .mc_start(mc_start), .mc_cycles(mc_cycles), .mc_cancel(mc_cancel),
        .flush_req(flush_req), .flush_pc(flush_pc), .stall(stall), .flush(flush),
        .new_pc(new_pc), .mc_busy(mc_busy), .mc_done(mc_done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic sid, input logic sex,
                                input logic st, input logic [5:0] cyc, input logic can,
                                input logic fr, input logic [31:0] fpc,
                                input logic [5:0] es, input logic ef, input logic [31:0] ep,
                                input logic eb, input logic ed);
        vec_t v;
        v.rst = r; v.sid = sid; v.sex = sex; v.start = st; v.cyc = cyc;
        v.cancel = can; v.freq = fr; v.fpc = fpc;
        v.e_stall = es; v.e_flush = ef; v.e_pc = ep; v.e_busy = eb; v.e_done = ed;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    endtask

    int step_no = 0;

    // One clock cycle: drive after the edge, push expectation, compare mid-cycle.
    task automatic step(input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        rst = v.rst; stallreq_id = v.sid; stallreq_ex = v.sex;
        mc_start = v.start; mc_cycles = v.cyc; mc_cancel = v.cancel;
        flush_req = v.freq; flush_pc = v.fpc;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        chk("stall",   step_no, {26'h0, stall},   {26'h0, e.e_stall});
        chk("flush",   step_no, {31'h0, flush},   {31'h0, e.e_flush});
        chk("new_pc",  step_no, new_pc,           e.e_pc);
        chk("mc_busy", step_no, {31'h0, mc_busy}, {31'h0, e.e_busy});
        chk("mc_done", step_no, {31'h0, mc_done}, {31'h0, e.e_done});
        step_no++;
    endtask

    task automatic idle(input logic [5:0] es, input logic eb, input logic ed);
        step(mk(0,0,0,0,0,0,0,0, es,0,0,eb,ed));
    endtask

    initial begin
        // Reset, load-use / EX overlap
        tbl.push_back(mk(1,1,1,0,0,0,0,0,         S0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         S0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,         SI,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,0,0,0,         SE,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0,0,0,         SE,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         S0,0,0,0,0));
        // Edge lengths 1, 0, 2, 3
        tbl.push_back(mk(0,0,0,1,1,0,0,0,         S0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         S0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,0,0,0,0,         S0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         S0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,2,0,0,0,         SE,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         S0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         S0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,3,0,0,0,         SE,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         SE,0,0,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,0,0,         SI,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         S0,0,0,0,0));
        // Flush aborting MULTI; mc_start and stallreq ignored during FLUSH
        tbl.push_back(mk(0,0,0,1,8,0,0,0,         SE,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         SE,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,32'h20,    S0,0,0,1,0));
        tbl.push_back(mk(0,1,0,1,5,0,0,0,         S0,1,32'h20,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         S0,0,0,0,0));
        // Back-to-back flush, flush beats stallreq_ex
        tbl.push_back(mk(0,0,1,0,0,0,1,32'h100,   S0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,32'h200,   S0,1,32'h100,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         S0,1,32'h200,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         S0,0,0,0,0));
        // Cancel during MULTI
        tbl.push_back(mk(0,0,0,1,6,0,0,0,         SE,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         SE,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,         S0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         S0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,4,0,0,0,         SE,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,1,0,0,         SI,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         S0,0,0,0,0));
        // mc_start ignored in MULTI
        tbl.push_back(mk(0,0,0,1,3,0,0,0,         SE,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,10,0,0,0,        SE,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         S0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         S0,0,0,0,0));
        // Flush wins over mc_start in IDLE
        tbl.push_back(mk(0,0,0,1,5,0,1,32'hABCD,  S0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         S0,1,32'hABCD,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,         S0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Divide-length op: N=34
        step(mk(0,0,0,1,34,0,0,0, SE,0,0,0,0));
        for (int i = 0; i < 32; i++) idle(SE, 1'b1, 1'b0);
        idle(S0, 1'b1, 1'b1);
        idle(S0, 1'b0, 1'b0);

        // Maximum length N=63
        step(mk(0,0,0,1,63,0,0,0, SE,0,0,0,0));
        for (int i = 0; i < 61; i++) idle(SE, 1'b1, 1'b0);
        idle(S0, 1'b1, 1'b1);
        idle(S0, 1'b0, 1'b0);

        // Reset mid-op: N=10, reset asserted in the 4th cycle
        step(mk(0,0,0,1,10,0,0,0, SE,0,0,0,0));
        idle(SE, 1'b1, 1'b0);
        idle(SE, 1'b1, 1'b0);
        step(mk(1,1,1,0,0,0,0,0, S0,0,0,0,0));
        for (int i = 0; i < 10; i++) idle(S0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
